// File: rtl/tdm_demux_if.sv
// Link-side bundle for the TDM receiver: slot beats in, decoded frame out.
interface tdm_demux_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 1,
  parameter int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) ();

  logic [W-1:0]     din;
  logic             din_valid;
  logic             frame_sync;
  logic [NCH*W-1:0] ch_out;
  logic             frame_valid;
  logic             locked;
  logic [SW-1:0]    slot;
  logic             sync_err;

  // Transmit side / stimulus: drives beats, observes the decoded frame.
  modport master (
    output din, din_valid, frame_sync,
    input  ch_out, frame_valid, locked, slot, sync_err
  );

  // Demux side: consumes beats, drives the decoded frame.
  modport slave (
    input  din, din_valid, frame_sync,
    output ch_out, frame_valid, locked, slot, sync_err
  );

endinterface

// File: rtl/tdm_demux.sv
// TDM receive demux: locks to slot-0 frame sync, gathers NCH slots into a
// shadow buffer and presents each complete frame on ch_out with a one-cycle
// frame_valid pulse. Aborted frames are never presented.
module tdm_demux #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 1,
  parameter int unsigned SW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic       clk,
  input  logic       reset,
  tdm_demux_if.slave bus
);

  localparam int unsigned   SHW       = (NCH - 1) * W;
  localparam int unsigned   CHW       = NCH * W;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NCH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [SHW-1:0]  shadow_q, shadow_d;
  logic [CHW-1:0]  ch_out_q, ch_out_d;
  logic            frame_valid_q, frame_valid_d;
  logic            sync_err_q, sync_err_d;
  logic            locked_q, locked_d;

  // State and datapath registers; async clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_out_q      <= ch_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  // Lock state transitions: sync locks from HUNT, a missing slot-0 sync drops lock.
  always_comb begin
    state_d = state_q;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: if (bus.frame_sync) state_d = LOCK;
        LOCK: if (!bus.frame_sync && (slot_q == '0)) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Slot tracking, shadow capture, frame presentation and error pulses.
  always_comb begin
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    ch_out_d      = ch_out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    locked_d      = (state_d == LOCK);
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shadow_d[W-1:0] = bus.din;
            slot_d          = SW'(1);
          end
        end
        LOCK: begin
          if (bus.frame_sync) begin
            // A sync anywhere but slot 0 restarts the frame at this beat.
            sync_err_d      = (slot_q != '0);
            shadow_d[W-1:0] = bus.din;
            slot_d          = SW'(1);
          end else if (slot_q == '0) begin
            sync_err_d = 1'b1;
            slot_d     = '0;
          end else if (slot_q == LAST_SLOT) begin
            ch_out_d      = {bus.din, shadow_q};
            frame_valid_d = 1'b1;
            slot_d        = '0;
          end else begin
            for (int unsigned k = 1; k < NCH - 1; k++) begin
              if (slot_q == SW'(k)) shadow_d[k*W +: W] = bus.din;
            end
            slot_d = slot_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ch_out      = ch_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = locked_q;
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: NCH=4/W=1 instance for lock, gap, error and
// reset behaviour; NCH=3/W=4 instance for multi-bit slots and back-to-back frames.
module tb_tdm_demux;

  logic clk;
  logic reset;

  tdm_demux_if #(.NCH(4), .W(1)) bus_a ();
  tdm_demux_if #(.NCH(3), .W(4)) bus_b ();

  tdm_demux #(.NCH(4), .W(1)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  tdm_demux #(.NCH(3), .W(4)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned fv_cnt_a = 0;
  int unsigned fv_cnt_b = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle of stimulus to instance 0 (A) or 1 (B) at a falling edge,
  // then wait to the next falling edge so outputs reflect the consuming edge.
  task automatic step(input int unsigned which, input logic v, input logic fs,
                      input logic [3:0] d);
    bus_a.din_valid  = 1'b0;
    bus_a.frame_sync = 1'b0;
    bus_a.din        = 1'b0;
    bus_b.din_valid  = 1'b0;
    bus_b.frame_sync = 1'b0;
    bus_b.din        = 4'h0;
    if (which == 0) begin
      bus_a.din_valid  = v;
      bus_a.frame_sync = fs;
      bus_a.din        = d[0];
    end else begin
      bus_b.din_valid  = v;
      bus_b.frame_sync = fs;
      bus_b.din        = d;
    end
    @(negedge clk);
    if (bus_a.frame_valid) fv_cnt_a++;
    if (bus_b.frame_valid) fv_cnt_b++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    bus_a.din_valid  = 1'b0;
    bus_a.frame_sync = 1'b0;
    bus_a.din        = 1'b0;
    bus_b.din_valid  = 1'b0;
    bus_b.frame_sync = 1'b0;
    bus_b.din        = 4'h0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_ch_out", 32'(bus_a.ch_out), 32'h0);
    check("rst_fv", 32'(bus_a.frame_valid), 32'h0);
    check("rst_locked", 32'(bus_a.locked), 32'h0);
    check("rst_slot", 32'(bus_a.slot), 32'h0);
    check("rst_err", 32'(bus_a.sync_err), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame 1,0,1,1 -> 4'b1101
    step(0, 1, 1, 4'h1);
    check("t1_locked", 32'(bus_a.locked), 32'h1);
    check("t1_slot1", 32'(bus_a.slot), 32'h1);
    step(0, 1, 0, 4'h0);
    step(0, 1, 0, 4'h1);
    check("t1_slot3", 32'(bus_a.slot), 32'h3);
    check("t1_no_fv", 32'(bus_a.frame_valid), 32'h0);
    step(0, 1, 0, 4'h1);
    check("t1_ch_out", 32'(bus_a.ch_out), 32'hD);
    check("t1_fv", 32'(bus_a.frame_valid), 32'h1);
    check("t1_slot0", 32'(bus_a.slot), 32'h0);
    check("t1_locked2", 32'(bus_a.locked), 32'h1);
    step(0, 0, 0, 4'h0);
    check("t1_fv_drop", 32'(bus_a.frame_valid), 32'h0);
    check("t1_ch_hold", 32'(bus_a.ch_out), 32'hD);

    // Same frame with 3-cycle gaps between beats
    fv_cnt_a = 0;
    step(0, 1, 1, 4'h1);
    repeat (3) step(0, 0, 0, 4'h0);
    step(0, 1, 0, 4'h0);
    repeat (3) step(0, 0, 0, 4'h0);
    check("t2_slot_hold", 32'(bus_a.slot), 32'h2);
    step(0, 1, 0, 4'h1);
    repeat (3) step(0, 0, 0, 4'h0);
    check("t2_no_fv_yet", 32'(fv_cnt_a), 32'h0);
    step(0, 1, 0, 4'h1);
    check("t2_ch_out", 32'(bus_a.ch_out), 32'hD);
    repeat (3) step(0, 0, 0, 4'h0);
    check("t2_fv_once", 32'(fv_cnt_a), 32'h1);

    // Missing sync on slot 0 -> unlock, then relock
    step(0, 1, 0, 4'h0);
    check("t3_err", 32'(bus_a.sync_err), 32'h1);
    check("t3_unlocked", 32'(bus_a.locked), 32'h0);
    check("t3_slot", 32'(bus_a.slot), 32'h0);
    check("t3_ch_keep", 32'(bus_a.ch_out), 32'hD);
    step(0, 0, 0, 4'h0);
    check("t3_err_drop", 32'(bus_a.sync_err), 32'h0);
    step(0, 1, 0, 4'h1);
    check("t3_hunt_discard", 32'(bus_a.locked), 32'h0);
    check("t3_hunt_slot", 32'(bus_a.slot), 32'h0);
    step(0, 1, 1, 4'h0);
    check("t3_relock", 32'(bus_a.locked), 32'h1);
    check("t3_relock_slot", 32'(bus_a.slot), 32'h1);

    // Early sync at slot 2, restart frame 0,1,1,0 -> 4'b0110
    fv_cnt_a = 0;
    step(0, 1, 0, 4'h1);
    check("t4_slot2", 32'(bus_a.slot), 32'h2);
    step(0, 1, 1, 4'h0);
    check("t4_err", 32'(bus_a.sync_err), 32'h1);
    check("t4_still_locked", 32'(bus_a.locked), 32'h1);
    check("t4_restart_slot", 32'(bus_a.slot), 32'h1);
    step(0, 1, 0, 4'h1);
    step(0, 1, 0, 4'h1);
    check("t4_no_partial", 32'(bus_a.ch_out), 32'hD);
    step(0, 1, 0, 4'h0);
    check("t4_ch_out", 32'(bus_a.ch_out), 32'h6);
    check("t4_fv_count", 32'(fv_cnt_a), 32'h1);

    // Asynchronous reset mid-frame at slot 2
    step(0, 1, 1, 4'h1);
    step(0, 1, 0, 4'h1);
    check("t5_slot2", 32'(bus_a.slot), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_ch", 32'(bus_a.ch_out), 32'h0);
    check("t5_async_lock", 32'(bus_a.locked), 32'h0);
    check("t5_async_slot", 32'(bus_a.slot), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    fv_cnt_a = 0;
    step(0, 1, 1, 4'h0);
    step(0, 1, 0, 4'h1);
    step(0, 1, 0, 4'h0);
    step(0, 1, 0, 4'h1);
    check("t5_ch_out", 32'(bus_a.ch_out), 32'hA);
    check("t5_fv_count", 32'(fv_cnt_a), 32'h1);

    // NCH=3, W=4: A,5,F -> 12'hF5A, then back-to-back 3,C,7 -> 12'h7C3
    step(1, 1, 1, 4'hA);
    check("b_locked", 32'(bus_b.locked), 32'h1);
    step(1, 1, 0, 4'h5);
    check("b_slot2", 32'(bus_b.slot), 32'h2);
    step(1, 1, 0, 4'hF);
    check("b_ch_out", 32'(bus_b.ch_out), 32'hF5A);
    check("b_fv", 32'(bus_b.frame_valid), 32'h1);
    step(1, 1, 1, 4'h3);
    check("b2_fv_gap1", 32'(bus_b.frame_valid), 32'h0);
    step(1, 1, 0, 4'hC);
    check("b2_fv_gap2", 32'(bus_b.frame_valid), 32'h0);
    check("b2_ch_hold", 32'(bus_b.ch_out), 32'hF5A);
    step(1, 1, 0, 4'h7);
    check("b2_fv", 32'(bus_b.frame_valid), 32'h1);
    check("b2_ch_out", 32'(bus_b.ch_out), 32'h7C3);
    check("b2_slot0", 32'(bus_b.slot), 32'h0);
    step(1, 0, 0, 4'h0);
    check("b_fv_total", 32'(fv_cnt_b), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
